// File: rtl/flag_ctrl_if.sv
// Flag/interrupt control bundle between the control unit, the ALU and flag_ctrl.
// Latency: none; this is wiring only.
// Backpressure: none; all signals are level-qualified single-cycle commands.
interface flag_ctrl_if;
  // ALU results
  logic ALU_C;
  logic ALU_Z;
  // flag commands from the control unit
  logic FLG_C_LD;
  logic FLG_Z_LD;
  logic FLG_C_SET;
  logic FLG_C_CLR;
  logic FLG_LD_SEL;
  logic FLG_SHAD_LD;
  // interrupt control
  logic I_SET;
  logic I_CLR;
  logic INT_IN;
  logic INT_ACK;
  // registered status
  logic C_FLAG;
  logic Z_FLAG;
  logic I_FLAG;
  logic INT_REQ;

  // control-unit / ALU side: drives commands, observes flags
  modport master (
    output ALU_C, ALU_Z,
    output FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_LD_SEL, FLG_SHAD_LD,
    output I_SET, I_CLR, INT_IN, INT_ACK,
    input  C_FLAG, Z_FLAG, I_FLAG, INT_REQ
  );

  // flag_ctrl side
  modport slave (
    input  ALU_C, ALU_Z,
    input  FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_LD_SEL, FLG_SHAD_LD,
    input  I_SET, I_CLR, INT_IN, INT_ACK,
    output C_FLAG, Z_FLAG, I_FLAG, INT_REQ
  );
endinterface

// File: rtl/flag_ctrl.sv
// C/Z flag registers with interrupt shadow, interrupt enable and synchronised pending latch.
// Latency: flags/enable one edge; INT_IN to pending SYNC_STAGES edges after first sampling edge.
// Backpressure: none; commands act every cycle, pending holds until INT_ACK.
module flag_ctrl #(
  parameter int SYNC_STAGES = 2,    // synchroniser depth on INT_IN, legal 2..4
  parameter bit INT_EDGE    = 1'b1  // 1 = rising-edge interrupt, 0 = level interrupt
) (
  input  logic       CLK,
  input  logic       RST,
  flag_ctrl_if.slave bus
);

  // architectural flags
  logic c_q, c_d;
  logic z_q, z_d;
  // shadow pair used across interrupt entry / return
  logic shad_c_q, shad_c_d;
  logic shad_z_q, shad_z_d;
  // interrupt enable and pending latch
  logic i_q, i_d;
  logic pend_q, pend_d;
  // INT_IN synchroniser chain; the top bit is the synchronised level
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // previous synchronised level, for edge detection
  logic hist_q, hist_d;

  logic ld_c_src;
  logic ld_z_src;
  logic int_sync;
  logic int_event;

  // Load source: ALU results normally, shadow pair when returning from interrupt.
  always_comb begin
    ld_c_src = bus.ALU_C;
    ld_z_src = bus.ALU_Z;
    if (bus.FLG_LD_SEL) begin
      ld_c_src = shad_c_q;
      ld_z_src = shad_z_q;
    end
  end

  // Carry next state: clear beats set beats load, otherwise hold.
  always_comb begin
    c_d = c_q;
    if (bus.FLG_C_CLR) begin
      c_d = 1'b0;
    end else if (bus.FLG_C_SET) begin
      c_d = 1'b1;
    end else if (bus.FLG_C_LD) begin
      c_d = ld_c_src;
    end
  end

  // Zero next state: load or hold.
  always_comb begin
    z_d = z_q;
    if (bus.FLG_Z_LD) begin
      z_d = ld_z_src;
    end
  end

  // Shadow captures the current registered flags, so a same-cycle restore swaps the pair.
  always_comb begin
    shad_c_d = shad_c_q;
    shad_z_d = shad_z_q;
    if (bus.FLG_SHAD_LD) begin
      shad_c_d = c_q;
      shad_z_d = z_q;
    end
  end

  // Interrupt enable: hardware clear on acceptance outranks software clear/set.
  always_comb begin
    i_d = i_q;
    if (bus.INT_ACK) begin
      i_d = 1'b0;
    end else if (bus.I_CLR) begin
      i_d = 1'b0;
    end else if (bus.I_SET) begin
      i_d = 1'b1;
    end
  end

  // Synchroniser shift and edge history; the event is formed from flopped values only.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.INT_IN};
    int_sync  = sync_q[SYNC_STAGES-1];
    hist_d    = int_sync;
    int_event = INT_EDGE ? (int_sync & ~hist_q) : int_sync;
  end

  // Pending: a new event wins over an acknowledge in the same cycle so no edge is lost.
  always_comb begin
    pend_d = pend_q;
    if (int_event) begin
      pend_d = 1'b1;
    end else if (bus.INT_ACK) begin
      pend_d = 1'b0;
    end
  end

  // State registers; reset clears everything immediately, independent of the clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      shad_c_q <= 1'b0;
      shad_z_q <= 1'b0;
      i_q      <= 1'b0;
      pend_q   <= 1'b0;
      sync_q   <= '0;
      hist_q   <= 1'b0;
    end else begin
      c_q      <= c_d;
      z_q      <= z_d;
      shad_c_q <= shad_c_d;
      shad_z_q <= shad_z_d;
      i_q      <= i_d;
      pend_q   <= pend_d;
      sync_q   <= sync_d;
      hist_q   <= hist_d;
    end
  end

  // Outputs come straight from registers; no input reaches an output combinationally.
  assign bus.C_FLAG  = c_q;
  assign bus.Z_FLAG  = z_q;
  assign bus.I_FLAG  = i_q;
  assign bus.INT_REQ = pend_q & i_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl: edge-mode and level-mode instances share one stimulus.
// Latency: checks every falling edge against a reference model plus literal spot checks.
// Backpressure: not applicable.
module tb_flag_ctrl;
  localparam int S = 2;

  logic clk;
  logic rst;
  logic alu_c, alu_z, c_ld, z_ld, c_set, c_clr, ld_sel, shad_ld;
  logic i_set, i_clr, int_in, int_ack;

  int checks;
  int errors;
  bit chk_en;

  flag_ctrl_if bus_e ();
  flag_ctrl_if bus_l ();

  assign bus_e.ALU_C = alu_c;         assign bus_l.ALU_C = alu_c;
  assign bus_e.ALU_Z = alu_z;         assign bus_l.ALU_Z = alu_z;
  assign bus_e.FLG_C_LD = c_ld;       assign bus_l.FLG_C_LD = c_ld;
  assign bus_e.FLG_Z_LD = z_ld;       assign bus_l.FLG_Z_LD = z_ld;
  assign bus_e.FLG_C_SET = c_set;     assign bus_l.FLG_C_SET = c_set;
  assign bus_e.FLG_C_CLR = c_clr;     assign bus_l.FLG_C_CLR = c_clr;
  assign bus_e.FLG_LD_SEL = ld_sel;   assign bus_l.FLG_LD_SEL = ld_sel;
  assign bus_e.FLG_SHAD_LD = shad_ld; assign bus_l.FLG_SHAD_LD = shad_ld;
  assign bus_e.I_SET = i_set;         assign bus_l.I_SET = i_set;
  assign bus_e.I_CLR = i_clr;         assign bus_l.I_CLR = i_clr;
  assign bus_e.INT_IN = int_in;       assign bus_l.INT_IN = int_in;
  assign bus_e.INT_ACK = int_ack;     assign bus_l.INT_ACK = int_ack;

  flag_ctrl #(.SYNC_STAGES(S), .INT_EDGE(1'b1)) dut_e (.CLK(clk), .RST(rst), .bus(bus_e.slave));
  flag_ctrl #(.SYNC_STAGES(S), .INT_EDGE(1'b0)) dut_l (.CLK(clk), .RST(rst), .bus(bus_l.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Architectural view: flags, shadow, enable, one pending bit per mode, and
  // a record of INT_IN as sampled on each rising edge (newest first).
  bit m_c, m_z, m_sc, m_sz, m_i, m_pe, m_pl;
  bit samp[$];
  bit nc, nz, ni, sync_now, sync_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_c = 0; m_z = 0; m_sc = 0; m_sz = 0; m_i = 0; m_pe = 0; m_pl = 0;
      samp = {};
      for (int k = 0; k <= S; k++) samp.push_back(1'b0);
    end else begin
      // synchronised level seen before this edge is INT_IN from S edges back
      sync_now  = samp[S-1];
      sync_prev = samp[S];
      nc = c_clr ? 1'b0 : c_set ? 1'b1 : c_ld ? (ld_sel ? m_sc : alu_c) : m_c;
      nz = z_ld ? (ld_sel ? m_sz : alu_z) : m_z;
      if (shad_ld) begin
        m_sc = m_c;
        m_sz = m_z;
      end
      ni = int_ack ? 1'b0 : i_clr ? 1'b0 : i_set ? 1'b1 : m_i;
      if (sync_now && !sync_prev) m_pe = 1'b1;
      else if (int_ack)           m_pe = 1'b0;
      if (sync_now)               m_pl = 1'b1;
      else if (int_ack)           m_pl = 1'b0;
      m_c = nc;
      m_z = nz;
      m_i = ni;
      samp.push_front(int_in);
      void'(samp.pop_back());
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model C_FLAG", bus_e.C_FLAG, m_c);
      check("model Z_FLAG", bus_e.Z_FLAG, m_z);
      check("model I_FLAG", bus_e.I_FLAG, m_i);
      check("model INT_REQ edge", bus_e.INT_REQ, m_pe & m_i);
      check("model INT_REQ level", bus_l.INT_REQ, m_pl & m_i);
      check("model C_FLAG level", bus_l.C_FLAG, m_c);
    end
  end

  task automatic idle();
    alu_c = 0; alu_z = 0; c_ld = 0; z_ld = 0; c_set = 0; c_clr = 0;
    ld_sel = 0; shad_ld = 0; i_set = 0; i_clr = 0; int_ack = 0;
  endtask

  // Advance n rising edges; returns just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 0;
    idle();
    int_in = 0;
    rst = 0;
    #1 rst = 1;
    tick(2);
    chk_en = 1;
    check("reset C", bus_e.C_FLAG, 1'b0);
    check("reset Z", bus_e.Z_FLAG, 1'b0);
    check("reset I", bus_e.I_FLAG, 1'b0);
    check("reset REQ", bus_e.INT_REQ, 1'b0);
    rst = 0;
    tick(1);

    // ---- flag operations ----
    alu_c = 1; alu_z = 0; c_ld = 1; z_ld = 1;
    tick(1);
    check("alu load C", bus_e.C_FLAG, 1'b1);
    check("alu load Z", bus_e.Z_FLAG, 1'b0);
    idle(); c_set = 1; c_clr = 1;
    tick(1);
    check("set+clr C", bus_e.C_FLAG, 1'b0);
    idle(); c_set = 1;
    tick(1);
    check("set C", bus_e.C_FLAG, 1'b1);
    idle();
    for (int k = 0; k < 4; k++) begin
      alu_c = k[0]; alu_z = ~k[0];
      tick(1);
    end
    check("hold C", bus_e.C_FLAG, 1'b1);
    check("hold Z", bus_e.Z_FLAG, 1'b0);
    idle(); alu_z = 1; z_ld = 1;
    tick(1);
    check("load Z1", bus_e.Z_FLAG, 1'b1);

    // ---- shadow round trip ----
    idle(); shad_ld = 1;
    tick(1);
    idle(); c_ld = 1; z_ld = 1;             // ALU 0/0
    tick(1);
    check("alu 00 C", bus_e.C_FLAG, 1'b0);
    check("alu 00 Z", bus_e.Z_FLAG, 1'b0);
    idle(); ld_sel = 1; c_ld = 1; z_ld = 1;
    tick(1);
    check("restore C", bus_e.C_FLAG, 1'b1);
    check("restore Z", bus_e.Z_FLAG, 1'b1);
    idle(); c_ld = 1; z_ld = 1;             // flags 00, shadow still 11
    tick(1);
    idle(); ld_sel = 1; c_ld = 1; z_ld = 1; shad_ld = 1;
    tick(1);
    check("swap C", bus_e.C_FLAG, 1'b1);
    check("swap Z", bus_e.Z_FLAG, 1'b1);
    idle(); ld_sel = 1; c_ld = 1; z_ld = 1;  // shadow must now be 00
    tick(1);
    check("swap shadow C", bus_e.C_FLAG, 1'b0);
    check("swap shadow Z", bus_e.Z_FLAG, 1'b0);

    // ---- edge interrupt ----
    idle(); i_set = 1;
    tick(1);
    idle();
    int_in = 1;
    tick(1);
    check("edge lat k", bus_e.INT_REQ, 1'b0);
    tick(1);
    check("edge lat k+1", bus_e.INT_REQ, 1'b0);
    tick(1);
    check("edge lat k+2", bus_e.INT_REQ, 1'b1);
    tick(1);
    int_ack = 1;
    tick(1);
    int_ack = 0;
    check("ack REQ", bus_e.INT_REQ, 1'b0);
    check("ack I", bus_e.I_FLAG, 1'b0);
    tick(4);
    i_set = 1;
    tick(1);
    i_set = 0;
    check("no retrigger", bus_e.INT_REQ, 1'b0);
    check("level reasserts", bus_l.INT_REQ, 1'b1);
    int_in = 0;
    tick(3);
    int_ack = 1;
    tick(1);
    int_ack = 0;

    // ---- masked interrupt then enable ----
    int_in = 1;
    tick(3);
    int_in = 0;
    tick(3);
    check("masked REQ", bus_e.INT_REQ, 1'b0);
    i_set = 1;
    tick(1);
    i_set = 0;
    check("enabled REQ", bus_e.INT_REQ, 1'b1);

    // ---- ack / event collision ----
    int_in = 1;
    tick(2);
    int_ack = 1;
    tick(1);
    int_ack = 0;
    check("collide I", bus_e.I_FLAG, 1'b0);
    i_set = 1;
    tick(1);
    i_set = 0;
    check("collide pending kept", bus_e.INT_REQ, 1'b1);
    int_in = 0;
    tick(3);
    int_ack = 1;
    tick(1);
    int_ack = 0;
    i_set = 1;
    tick(1);
    i_set = 0;
    check("pending cleared", bus_e.INT_REQ, 1'b0);
    int_ack = 1;                             // ACK with nothing pending
    tick(1);
    int_ack = 0;
    check("idle ack I", bus_e.I_FLAG, 1'b0);

    // ---- reset mid-operation ----
    c_set = 1; alu_z = 1; z_ld = 1; i_set = 1; int_in = 1;
    tick(1);
    idle();
    tick(2);
    check("pre-rst C", bus_e.C_FLAG, 1'b1);
    check("pre-rst Z", bus_e.Z_FLAG, 1'b1);
    check("pre-rst REQ", bus_e.INT_REQ, 1'b1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("async rst C", bus_e.C_FLAG, 1'b0);
    check("async rst Z", bus_e.Z_FLAG, 1'b0);
    check("async rst I", bus_e.I_FLAG, 1'b0);
    check("async rst REQ", bus_e.INT_REQ, 1'b0);
    check("async rst REQ lvl", bus_l.INT_REQ, 1'b0);
    tick(2);
    check("rst hold C", bus_e.C_FLAG, 1'b0);
    check("rst hold REQ", bus_e.INT_REQ, 1'b0);
    int_in = 0;
    rst = 0;
    tick(3);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flag_ctrl.md
Name: flag_ctrl

Overview:
- Flag and interrupt-control stage directly downstream of the MCU ALU.
- Registers the ALU's combinational C/Z outputs under control-unit command and provides SET/CLR of C.
- Saves and restores C/Z through a shadow pair on interrupt entry and return.
- Owns the interrupt-enable flag plus a synchronised, edge-detected interrupt-pending latch; C_FLAG feeds back to the ALU CIN input.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on INT_IN (legal 2..4)
INT_EDGE, 1, 1 = rising-edge-triggered interrupt, 0 = level-triggered

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
ALU_C  input  1  carry from ALU
ALU_Z  input  1  zero from ALU
FLG_C_LD  input  1  load C from selected source
FLG_Z_LD  input  1  load Z from selected source
FLG_C_SET  input  1  force C=1
FLG_C_CLR  input  1  force C=0
FLG_LD_SEL  input  1  0 = loads take ALU_C/ALU_Z, 1 = loads take shadow C/Z (RETI restore)
FLG_SHAD_LD  input  1  copy current C_FLAG/Z_FLAG into shadow (interrupt entry)
I_SET  input  1  set interrupt enable (SEI / RETIE)
I_CLR  input  1  clear interrupt enable (CLI / RETID)
INT_IN  input  1  raw asynchronous external interrupt line
INT_ACK  input  1  control unit accepted interrupt this cycle
C_FLAG  output  1  registered carry (to ALU CIN, branch logic)
Z_FLAG  output  1  registered zero
I_FLAG  output  1  interrupt enable
INT_REQ  output  1  pending & I_FLAG, combinational from registers only

Behaviour:
- Reset: asynchronous on RST high. C_FLAG, Z_FLAG, shadow C, shadow Z, I_FLAG, pending, synchroniser chain and edge-history flop all go to 0. INT_REQ is therefore 0. Clearing is immediate, not clock-gated, and takes effect mid-operation.
- C next-state priority, highest first:
  - FLG_C_CLR: 0.
  - FLG_C_SET: 1.
  - FLG_C_LD: source selected by FLG_LD_SEL.
  - Otherwise: hold.
  - CLR and SET together: CLR wins.
- Z next-state:
  - FLG_Z_LD: source selected by FLG_LD_SEL.
  - Otherwise: hold.
- Shadow:
  - FLG_SHAD_LD captures the pre-edge C_FLAG/Z_FLAG, i.e. the register values, not the next-state.
  - SHAD_LD with C_LD/Z_LD in the same cycle: shadow gets old flags; flags get new source.
  - FLG_LD_SEL=1 with SHAD_LD in the same cycle: flags get old shadow; shadow gets old flags (swap).
- I_FLAG next-state priority, highest first:
  - INT_ACK: 0 (hardware disables on entry).
  - I_CLR: 0.
  - I_SET: 1.
  - Otherwise: hold.
- Interrupt path:
  - INT_IN → SYNC_STAGES-flop chain → sync.
  - One history flop holds the previous sync value.
  - INT_EDGE=1: event = sync & ~hist.
  - INT_EDGE=0: event = sync.
- Pending next-state:
  - event: 1. Event wins over INT_ACK in the same cycle, so no edge is lost.
  - INT_ACK: 0.
  - Otherwise: hold.
  - Pending latches independently of I_FLAG. An interrupt arriving while disabled is held and raises INT_REQ when I_FLAG is later set.
- Latency (INT_EDGE=1, SYNC_STAGES=2): INT_IN high before edge k → pending set at edge k+2 → INT_REQ high after edge k+2, if I_FLAG=1. In general: SYNC_STAGES edges after the first sampling edge.
- Edge mode: INT_IN held high produces exactly one pending set. A new set requires INT_IN low for at least one synchronised sample.
- Level mode: pending re-asserts every cycle sync=1, including the cycle after ACK.
- INT_ACK while pending=0: clears I_FLAG only; no other effect.
- No combinational path from any input to any output. INT_REQ depends only on pending and I_FLAG.

Test Plan:
- Reset mid-operation: C=1, Z=1, I=1, pending=1; assert RST between clock edges → all outputs 0 immediately, before next CLK edge; hold 0 while RST high.
- Flag ops:
  - ALU_C=1, ALU_Z=0, C_LD=Z_LD=1 → C=1, Z=0 next edge.
  - C_SET+C_CLR together → C=0.
  - C_SET alone → C=1.
  - Loads deasserted, ALU inputs toggling → flags hold.
- Shadow round-trip:
  - C=1, Z=1, SHAD_LD → shadow=11.
  - Then ALU load 0/0 → flags 00.
  - Then LD_SEL=1 with C_LD=Z_LD=1 → flags 11.
  - Same-cycle SHAD_LD+LD_SEL with flags 00, shadow 11 → flags 11, shadow 00.
- Edge interrupt, INT_EDGE=1:
  - I=1; INT_IN rises before edge 10 and stays high 20 cycles → INT_REQ rises after edge 12.
  - INT_ACK at edge 14 → INT_REQ=0, I=0, no re-trigger while INT_IN high.
- Masked interrupt then enable: I=0; pulse INT_IN 3 cycles → pending=1, INT_REQ=0; I_SET → INT_REQ=1 next edge.
- ACK/event collision: second INT_IN edge's event coincides with INT_ACK edge → pending stays 1, I=0. Level mode: INT_IN held high, ACK → pending re-asserts next edge.
